// File: rtl/fdclk_cnt_pkg.sv
// Shared constants for the fdclk event counter: count direction values and
// the rise-detector state encoding.
package fdclk_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ARMED = 1'b0,  // fdclk last seen low; next high level is an event
        SEEN  = 1'b1   // fdclk last seen high; wait for it to drop
    } det_state_e;

endpackage

// File: rtl/fdclk_counter_rise_det.sv
// Rise detector for the divided-clock level: emits a one-cycle tick on the
// first clk edge that sees fdclk high after it was low, gated by en.
module rise_det
    import fdclk_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    input  logic fdclk,
    output logic tick
);

    det_state_e state_q, state_d;

    // Resets to SEEN: the divider leaves reset with fdclk high and that level
    // must not be counted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= SEEN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = fdclk ? SEEN : ARMED;
    end

    always_comb begin
        tick = (state_q == ARMED) && fdclk && en;
    end

endmodule

// File: rtl/fdclk_counter.sv
// Modulo-(MAX+1) up/down counter of fdclk rising edges with clear, load,
// terminal-count pulse and sticky overflow. FDCLK_CNT_SAT_EN selects
// saturation instead of wrap at the count boundaries.
module fdclk_counter
    import fdclk_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    input  logic             fdclk,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

`ifdef FDCLK_CNT_SAT_EN
    localparam logic [WIDTH-1:0] UP_BOUND_V = MAX_V;
    localparam logic [WIDTH-1:0] DN_BOUND_V = ZERO_V;
`else
    localparam logic [WIDTH-1:0] UP_BOUND_V = ZERO_V;
    localparam logic [WIDTH-1:0] DN_BOUND_V = MAX_V;
`endif

    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    rise_det u_rise_det (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (en),
        .fdclk (fdclk),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        boundary = 1'b0;
        ovf_d    = ovf_q;

        if (clr) begin
            cnt_d = ZERO_V;
            ovf_d = 1'b0;
        end else if (ld) begin
            cnt_d = (din > MAX_V) ? MAX_V : din;
            ovf_d = 1'b0;
        end else if (tick) begin
            case (dir)
                DIR_UP: begin
                    if (cnt_q < MAX_V) begin
                        cnt_d = cnt_q + ONE_V;
                    end else begin
                        boundary = 1'b1;
                        cnt_d    = UP_BOUND_V;
                    end
                end
                DIR_DOWN: begin
                    if (cnt_q > ZERO_V) begin
                        cnt_d = cnt_q - ONE_V;
                    end else begin
                        boundary = 1'b1;
                        cnt_d    = DN_BOUND_V;
                    end
                end
                default: ;
            endcase
        end

        if (boundary) begin
            ovf_d = 1'b1;
        end
        tc_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= ZERO_V;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_fdclk_counter.sv
// Self-checking bench for fdclk_counter, driven by a behavioural divide-by-3
// stage and compared against an edge-counting reference model.
module tb_fdclk_counter;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;
`ifdef FDCLK_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk;
    logic             rst_b;
    logic             clr;
    logic             en;
    logic             fdclk;
    logic             dir;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             ovf;

    int checks;
    int failures;

    // Reference model state
    int m_cnt;
    bit m_tc;
    bit m_ovf;
    bit m_prev;   // fdclk level sampled at the previous edge
    // Divider model: fdclk high in phase 0, advances when c_up is set
    int div_ph;
    bit c_up;

    fdclk_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr),
        .en    (en),
        .fdclk (fdclk),
        .dir   (dir),
        .ld    (ld),
        .din   (din),
        .cnt   (cnt),
        .tc    (tc),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt  = 0;
        m_tc   = 1'b0;
        m_ovf  = 1'b0;
        m_prev = 1'b1;
    endtask

    // Update the model from the current inputs, take one clock edge, then
    // advance the divider just after the edge.
    task automatic cycle();
        bit ev;
        int nxt;
        ev     = fdclk && !m_prev && en;
        m_prev = fdclk;
        m_tc   = 1'b0;
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (ld) begin
            m_cnt = (int'(din) > MAX) ? MAX : int'(din);
            m_ovf = 1'b0;
        end else if (ev) begin
            nxt = dir ? m_cnt + 1 : m_cnt - 1;
            if (nxt < 0 || nxt > MAX) begin
                m_tc  = 1'b1;
                m_ovf = 1'b1;
                nxt   = SAT ? m_cnt : (nxt + MAX + 1) % (MAX + 1);
            end
            m_cnt = nxt;
        end
        @(posedge clk);
        #1;
        if (c_up) div_ph = (div_ph + 1) % 3;
        fdclk = (div_ph == 0);
    endtask

    task automatic run_until_fdclk(input bit want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (fdclk == want) ok = 1'b1;
            else cycle();
        end
        if (fdclk == want) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_b  = 1'b0;
        clr    = 1'b0;
        ld     = 1'b0;
        din    = '0;
        en     = 1'b1;
        dir    = 1'b1;
        c_up   = 1'b1;
        div_ph = 0;
        fdclk  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_count_up();
        en = 1'b1; dir = 1'b1; c_up = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL up_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
            checks++;
            if (tc !== m_tc) begin failures++; $display("FAIL up_tc cyc=%0d got=%b exp=%b", i, tc, m_tc); end
            checks++;
            if (ovf !== m_ovf) begin failures++; $display("FAIL up_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
        end
    endtask

    task automatic test_count_down();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        dir = 1'b0;
        for (int i = 0; i < 36; i++) begin
            cycle();
            checks++;
            if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL down_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
            checks++;
            if (tc !== m_tc) begin failures++; $display("FAIL down_tc cyc=%0d got=%b exp=%b", i, tc, m_tc); end
            checks++;
            if (ovf !== m_ovf) begin failures++; $display("FAIL down_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        dir = 1'b1; c_up = 1'b1;
        run_until_fdclk(1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_wait_low got=timeout exp=fdclk_low"); end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        run_until_fdclk(1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_wait_high got=timeout exp=fdclk_high"); end
        c_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
        end
        checks++;
        if (cnt !== WIDTH'(1)) begin failures++; $display("FAIL stall_single_event got=%0d exp=1", cnt); end
        c_up = 1'b1;
    endtask

    task automatic test_load();
        bit ok;
        dir = 1'b1; en = 1'b1; c_up = 1'b1;
        run_until_fdclk(1'b0, ok);
        run_until_fdclk(1'b1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL load_wait_rise got=timeout exp=fdclk_high"); end
        ld  = 1'b1;
        din = 4'd13;
        cycle();
        ld = 1'b0;
        checks++;
        if (cnt !== WIDTH'(MAX)) begin failures++; $display("FAIL load_clamp_cnt got=%0d exp=%0d", cnt, MAX); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL load_tc got=%b exp=0", tc); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL load_ovf got=%b exp=0", ovf); end
        clr = 1'b1;
        ld  = 1'b1;
        din = 4'd5;
        cycle();
        clr = 1'b0;
        ld  = 1'b0;
        checks++;
        if (cnt !== '0) begin failures++; $display("FAIL clr_over_ld got=%0d exp=0", cnt); end
        checks++;
        if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL clr_model got=%0d exp=%0d", cnt, m_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            dir  = $urandom_range(0, 1) == 1;
            c_up = ($urandom_range(0, 4) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            ld   = ($urandom_range(0, 15) == 0);
            din  = WIDTH'($urandom_range(0, 15));
            cycle();
            checks++;
            if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
            checks++;
            if (tc !== m_tc) begin failures++; $display("FAIL rand_tc cyc=%0d got=%b exp=%b", i, tc, m_tc); end
            checks++;
            if (ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
        end
        clr = 1'b0; ld = 1'b0; en = 1'b1; dir = 1'b1; c_up = 1'b1;
    endtask

    task automatic test_async_reset();
        ld  = 1'b1;
        din = 4'd6;
        cycle();
        ld = 1'b0;
        checks++;
        if (cnt !== WIDTH'(6)) begin failures++; $display("FAIL areset_pre_cnt got=%0d exp=6", cnt); end
        // Present a fresh high level that would otherwise be counted.
        c_up   = 1'b0;
        div_ph = 0;
        fdclk  = 1'b1;
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (cnt !== '0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", cnt); end
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL areset_tc got=%b exp=0", tc); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b exp=0", ovf); end
        #24;
        rst_b = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (cnt !== '0) begin failures++; $display("FAIL areset_hold cyc=%0d got=%0d exp=0", i, cnt); end
        end
        c_up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            checks++;
            if (cnt !== WIDTH'(m_cnt)) begin failures++; $display("FAIL areset_resume cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count_up();
        test_count_down();
        test_stall();
        test_load();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
